// File: rtl/edge_pattern_gen.sv
// edge_pattern_gen
//   Turns a queue of edge commands into a glitch-free level waveform.
//   Commands are RISE, FALL, TOGGLE and PULSE. Each command carries a hold
//   count: the number of idle cycles after the command completes before the
//   next command is allowed to apply. Commands are buffered in a small FIFO
//   behind a valid/ready port.
//
// Parameters
//   CNT_W      width of the hold count
//   DEPTH      command FIFO depth (power of two, >= 2)
//   INIT_LEVEL level of wave_out after reset
//
// Ports
//   clk         single clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   abort       synchronous flush (only when EDGE_GEN_ABORT_EN is defined)
//   cmd_valid   command present
//   cmd_ready   FIFO not full (and no abort); accept on valid & ready
//   cmd_type    00 RISE, 01 FALL, 10 TOGGLE, 11 PULSE
//   cmd_hold    idle cycles after the command completes
//   wave_out    generated waveform, registered
//   edge_strobe high in exactly the cycles where wave_out shows a new level
//   busy        FSM not idle or FIFO non-empty
//
// Build option
//   EDGE_GEN_ABORT_EN  adds the abort port and its flush logic.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | waiting; pops and applies the FIFO head when one exists
// S_HOLD       | counting down the hold time of the last command
// S_PULSE_BACK | restoring the pre-pulse level (second edge of a PULSE)

module edge_pattern_gen #(
  parameter int   CNT_W      = 8,
  parameter int   DEPTH      = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef EDGE_GEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_type,
  input  logic [CNT_W-1:0] cmd_hold,
  output logic             wave_out,
  output logic             edge_strobe,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] CMD_RISE   = 2'b00;
  localparam logic [1:0] CMD_FALL   = 2'b01;
  localparam logic [1:0] CMD_PULSE  = 2'b11;

  localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_HOLD       = 2'd1,
    S_PULSE_BACK = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        fifo_type [DEPTH];
  logic [CNT_W-1:0]  fifo_hold [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [1:0]        head_type;
  logic [CNT_W-1:0]  head_hold;
  logic              next_level;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef EDGE_GEN_ABORT_EN
  assign cmd_ready = !full && !abort;
`else
  assign cmd_ready = !full;
`endif

  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign head_type = fifo_type[rd_ptr[AW-1:0]];
  assign head_hold = fifo_hold[rd_ptr[AW-1:0]];
  assign busy      = (state != S_IDLE) || !empty;

  // TOGGLE and PULSE both invert on their first edge.
  always_comb begin
    next_level = ~wave_out;
    case (head_type)
      CMD_RISE: next_level = 1'b1;
      CMD_FALL: next_level = 1'b0;
      default:  next_level = ~wave_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_type[i] <= '0;
        fifo_hold[i] <= '0;
      end
    end
`ifdef EDGE_GEN_ABORT_EN
    else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end
`endif
    else begin
      if (push) begin
        fifo_type[wr_ptr[AW-1:0]] <= cmd_type;
        fifo_hold[wr_ptr[AW-1:0]] <= cmd_hold;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wave_out    <= INIT_LEVEL;
      edge_strobe <= 1'b0;
    end
`ifdef EDGE_GEN_ABORT_EN
    else if (abort) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wave_out    <= INIT_LEVEL;
      edge_strobe <= (wave_out != INIT_LEVEL);
    end
`endif
    else begin
      case (state)
        S_IDLE: begin
          edge_strobe <= 1'b0;
          if (!empty) begin
            wave_out    <= next_level;
            edge_strobe <= (next_level != wave_out);
            // For PULSE the hold is parked in cnt until the second edge.
            cnt         <= head_hold;
            if (head_type == CMD_PULSE) begin
              state <= S_PULSE_BACK;
            end else if (head_hold != '0) begin
              state <= S_HOLD;
            end
          end
        end
        S_PULSE_BACK: begin
          wave_out    <= ~wave_out;
          edge_strobe <= 1'b1;
          state       <= (cnt != '0) ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          edge_strobe <= 1'b0;
          cnt         <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= S_IDLE;
          end
        end
        default: begin
          edge_strobe <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_pattern_gen.sv
// tb_edge_pattern_gen
//   Directed testbench for edge_pattern_gen with hand-computed expectations.
//   Edge numbers in tags count rising edges after reset release (e1 = first).
//   Build with EDGE_GEN_ABORT_EN to include the abort scenario.

module tb_edge_pattern_gen;

  localparam logic [1:0] RISE   = 2'b00;
  localparam logic [1:0] FALL   = 2'b01;
  localparam logic [1:0] TOGGLE = 2'b10;
  localparam logic [1:0] PULSE  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_hold = 8'd0;
  logic       cmd_ready;
  logic       wave_out;
  logic       edge_strobe;
  logic       busy;
`ifdef EDGE_GEN_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  edge_pattern_gen #(
    .CNT_W      (8),
    .DEPTH      (4),
    .INIT_LEVEL (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef EDGE_GEN_ABORT_EN
    .abort       (abort),
`endif
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_type    (cmd_type),
    .cmd_hold    (cmd_hold),
    .wave_out    (wave_out),
    .edge_strobe (edge_strobe),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [7:0] h);
    cmd_valid = v;
    cmd_type  = t;
    cmd_hold  = h;
  endtask

  task automatic do_reset();
    drive(1'b0, RISE, 8'd0);
`ifdef EDGE_GEN_ABORT_EN
    abort = 1'b0;
`endif
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Loads RISE h10 (applied at e2), then queues FALL and TOGGLE.
  task automatic setup_hold_with_queue();
    do_reset();
    drive(1'b1, RISE, 8'd10);
    tick();
    drive(1'b1, FALL, 8'd0);
    tick();
    drive(1'b1, TOGGLE, 8'd0);
    tick();
    drive(1'b0, RISE, 8'd0);
  endtask

  initial begin
    bit [0:7]  w2, s2;
    bit [0:4]  w3, s3;
    bit [0:3]  w4, s4;
    bit [0:17] w5, s5;
    logic [1:0] t5 [5];
    logic [7:0] h5 [5];
    int strobes;
    int hi;
    int bad;

    // Reset state and single TOGGLE hold=0.
    do_reset();
    check_eq("rst_wave", wave_out, 0);
    check_eq("rst_strobe", edge_strobe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 1);
    drive(1'b1, TOGGLE, 8'd0);
    tick();
    drive(1'b0, RISE, 8'd0);
    check_eq("t1_wave_e1", wave_out, 0);
    check_eq("t1_busy_e1", busy, 1);
    tick();
    check_eq("t1_wave_e2", wave_out, 1);
    check_eq("t1_strobe_e2", edge_strobe, 1);
    tick();
    check_eq("t1_wave_e3", wave_out, 1);
    check_eq("t1_strobe_e3", edge_strobe, 0);
    check_eq("t1_busy_e3", busy, 0);

    // RISE hold=3 then FALL hold=0: rise at e2, fall at e6.
    do_reset();
    drive(1'b1, RISE, 8'd3);
    tick();
    drive(1'b1, FALL, 8'd0);
    tick();
    drive(1'b0, RISE, 8'd0);
    w2 = 8'b11110000;
    s2 = 8'b10001000;
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check_eq($sformatf("t2_wave_e%0d", i + 2), wave_out, w2[i]);
      check_eq($sformatf("t2_strobe_e%0d", i + 2), edge_strobe, s2[i]);
      strobes += int'(edge_strobe);
    end
    check_eq("t2_strobe_count", strobes, 2);
    check_eq("t2_busy_end", busy, 0);

    // RISE while high (hold=2) then TOGGLE: RISE at e4 silent, TOGGLE at e7.
    do_reset();
    drive(1'b1, RISE, 8'd0);
    tick();
    drive(1'b0, RISE, 8'd0);
    tick();
    check_eq("t3_wave_e2", wave_out, 1);
    drive(1'b1, RISE, 8'd2);
    tick();
    drive(1'b1, TOGGLE, 8'd0);
    tick();
    drive(1'b0, RISE, 8'd0);
    w3 = 5'b11100;
    s3 = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check_eq($sformatf("t3_wave_e%0d", i + 4), wave_out, w3[i]);
      check_eq($sformatf("t3_strobe_e%0d", i + 4), edge_strobe, s3[i]);
    end

    // PULSE hold=0 from 0: one-cycle high, two strobe cycles.
    do_reset();
    drive(1'b1, PULSE, 8'd0);
    tick();
    drive(1'b0, RISE, 8'd0);
    w4 = 4'b1000;
    s4 = 4'b1100;
    hi = 0;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("t4_wave_e%0d", i + 2), wave_out, w4[i]);
      check_eq($sformatf("t4_strobe_e%0d", i + 2), edge_strobe, s4[i]);
      hi += int'(wave_out);
      strobes += int'(edge_strobe);
    end
    check_eq("t4_high_cycles", hi, 1);
    check_eq("t4_strobe_cycles", strobes, 2);

    // Five commands into a 4-deep FIFO while the first holds 10 cycles.
    t5[0] = TOGGLE; h5[0] = 8'd10;
    t5[1] = FALL;   h5[1] = 8'd0;
    t5[2] = RISE;   h5[2] = 8'd1;
    t5[3] = PULSE;  h5[3] = 8'd0;
    t5[4] = FALL;   h5[4] = 8'd0;
    w5 = 18'b111111111110110100;
    s5 = 18'b100000000001101110;
    do_reset();
    drive(1'b1, t5[0], h5[0]);
    tick();
    for (int i = 0; i < 18; i++) begin
      if (i < 4) begin
        check_eq($sformatf("t5_ready_push%0d", i + 2), cmd_ready, 1);
        drive(1'b1, t5[i + 1], h5[i + 1]);
      end else begin
        drive(1'b0, RISE, 8'd0);
      end
      tick();
      check_eq($sformatf("t5_wave_e%0d", i + 2), wave_out, w5[i]);
      check_eq($sformatf("t5_strobe_e%0d", i + 2), edge_strobe, s5[i]);
      if (i == 3)  check_eq("t5_ready_full_e5", cmd_ready, 0);
      if (i == 10) check_eq("t5_ready_full_e12", cmd_ready, 0);
      if (i == 11) check_eq("t5_ready_free_e13", cmd_ready, 1);
    end
    check_eq("t5_busy_end", busy, 0);

    // Async reset mid-HOLD with two commands queued.
    setup_hold_with_queue();
    check_eq("t6_wave_hold", wave_out, 1);
    check_eq("t6_busy_hold", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_wave_async", wave_out, 0);
    check_eq("t6_busy_async", busy, 0);
    check_eq("t6_ready_async", cmd_ready, 1);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (wave_out !== 1'b0 || edge_strobe !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_eq("t6_no_queued_exec", bad, 0);

`ifdef EDGE_GEN_ABORT_EN
    // Synchronous abort mid-HOLD; the command offered alongside is refused.
    setup_hold_with_queue();
    check_eq("t7_wave_hold", wave_out, 1);
    abort = 1'b1;
    drive(1'b1, RISE, 8'd0);
    #1;
    check_eq("t7_ready_abort", cmd_ready, 0);
    check_eq("t7_wave_before_edge", wave_out, 1);
    tick();
    abort = 1'b0;
    drive(1'b0, RISE, 8'd0);
    check_eq("t7_wave_abort", wave_out, 0);
    check_eq("t7_strobe_abort", edge_strobe, 1);
    check_eq("t7_busy_abort", busy, 0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (wave_out !== 1'b0 || edge_strobe !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_eq("t7_no_queued_exec", bad, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_pattern_gen.md
# edge_pattern_gen

Synthesizes edges: it turns a queue of edge commands (rise, fall, toggle, pulse) into a glitch-free level waveform on `wave_out`, with a programmable hold time after each edge. It is the generating counterpart of the clock edge detector. Its output is fed to edge-detection logic or used as a test/strobe waveform in the same clock domain. Commands enter through a valid/ready port backed by a small FIFO.

## Interface
- `CNT_W`, default 8: width of the hold count.
- `DEPTH`, default 4: command FIFO depth; power of two, ≥2.
- `INIT_LEVEL`, default 1'b0: level of `wave_out` after reset.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full; command accepted on `cmd_valid & cmd_ready` at a rising edge.
- `cmd_type`  in  2  edge command: 00 RISE, 01 FALL, 10 TOGGLE, 11 PULSE.
- `cmd_hold`  in  CNT_W  idle cycles after the command completes, before the next command may apply.
- `wave_out`  out  1  generated waveform, registered.
- `edge_strobe`  out  1  high for exactly the cycles in which `wave_out` shows a new level.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.

## Operation
- FIFO: DEPTH entries of {type, hold}. `cmd_ready = !full` (combinational from registered pointers). A push while full cannot occur. Push and pop in the same cycle are both performed. Pointers wrap modulo DEPTH and use an extra wrap bit for full/empty.
- FSM states: IDLE, HOLD, PULSE_BACK.
- IDLE, FIFO non-empty: pop the head and apply it at this edge.
  - RISE: `wave_out` ← 1.
  - FALL: `wave_out` ← 0.
  - TOGGLE: `wave_out` ← ~`wave_out`.
  - PULSE: `wave_out` ← ~`wave_out`, then go to PULSE_BACK.
  - Other types: if hold > 0, load the counter with hold and go to HOLD; else stay in IDLE.
- RISE when already 1, or FALL when already 0: no level change and no strobe. The hold still elapses.
- PULSE_BACK: restore the pre-pulse level, which gives a second edge. Then go to HOLD (hold > 0) or IDLE.
- HOLD: decrement the counter each cycle. Go to IDLE when the counter reaches 1 on the decrementing edge, so exactly hold cycles are spent in HOLD.
- IDLE with an empty FIFO: `wave_out` keeps its level indefinitely.
- `edge_strobe` is registered. It is set on the same edge that changes `wave_out` and cleared on any edge with no change.

## Timing
- Reset values: `wave_out` = INIT_LEVEL, `edge_strobe` = 0, `busy` = 0, `cmd_ready` = 1, FSM = IDLE, FIFO empty, counter = 0.
- Latency with an empty FIFO and the FSM in IDLE: a command accepted at edge k is applied at edge k+1. `wave_out` shows the new level after edge k+1.
- If a command is applied at edge t, the next command applies no earlier than:
  - edge t+1+hold for RISE, FALL or TOGGLE;
  - edge t+2+hold for PULSE.
- PULSE output is a 1-cycle-wide pulse. `edge_strobe` is high for 2 consecutive cycles.
- Back-to-back commands with hold = 0 toggle every cycle. `edge_strobe` then stays high continuously.
- `busy` is registered-state derived. It falls in the first cycle with FSM = IDLE and the FIFO empty.
- Reset assertion mid-operation: all state returns to reset values immediately, regardless of clock. Queued commands are discarded.

## Configuration
- `EDGE_GEN_ABORT_EN` defined adds input port `abort` (1 bit, synchronous).
  - When `abort` is sampled high, the FIFO is flushed, the FSM goes to IDLE, the counter clears, and `wave_out` ← INIT_LEVEL on the next edge.
  - `edge_strobe` pulses only if the level actually changed.
  - A command offered with `abort` high is not accepted; `cmd_ready` is forced low that cycle.
- `EDGE_GEN_ABORT_EN` undefined: no `abort` port and no flush logic. Behaviour is otherwise identical.

## Test plan
- Reset with INIT_LEVEL = 0, then TOGGLE hold = 0 accepted at edge 1 → `wave_out` = 1 after edge 2; `edge_strobe` = 1 for one cycle; `busy` = 0 after edge 3.
- RISE hold = 3, then FALL hold = 0, accepted back-to-back → `wave_out` rises at edge t and falls at edge t+4; exactly two strobes.
- RISE while `wave_out` = 1, hold = 2, then TOGGLE → no strobe for the RISE; TOGGLE applies 3 edges after the RISE.
- PULSE hold = 0 from level 0 → `wave_out` = 1 for exactly 1 cycle; `edge_strobe` high 2 cycles.
- Push 5 commands with DEPTH = 4 while the first holds 10 cycles → `cmd_ready` low once 4 are queued; all 5 are executed in order with no loss.
- Assert `rst_n` low mid-HOLD with 2 queued, then release → `wave_out` = INIT_LEVEL, `busy` = 0, queued commands never execute. With `EDGE_GEN_ABORT_EN`, repeat using `abort` → same result, synchronous.
